// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I encodings for the ALU issue slice.
// Provides opcode constants, ALU control encodings (including the SLT/SLTU
// remap targets), funct7 constants, the issue FSM state type and a helper
// that maps an instruction funct3 onto the ALU control field.
package rv32_pkg;

  // Major opcodes handled by the issue unit
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // ALU control encodings
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLTU = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // The ALU orders its compare ops unsigned-first, the ISA signed-first,
  // so funct3 010/011 swap; everything else passes straight through.
  function automatic logic [2:0] map_f3(input logic [2:0] f3);
    logic [2:0] ctrl;
    case (f3)
      3'b010:  ctrl = ALU_SLT;
      3'b011:  ctrl = ALU_SLTU;
      default: ctrl = f3;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec: purely combinational RV32I decode for the ALU issue stage.
// Ports:
//   instr, pc, rs1_data, rs2_data  (in)  instruction word, its address, RF reads
//   x_o, y_o                       (out) next ALU operands
//   ctrl_o, ex_o                   (out) next ALU op select and SUB/SRA modifier
//   rd_we_o                        (out) writeback enable (legal and rd != x0)
//   illegal_o                      (out) encoding is not a supported ALU op
// Illegal encodings force all operand/control outputs to zero.
module alu_issue_dec
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] x_o,
  output logic [31:0] y_o,
  output logic [2:0]  ctrl_o,
  output logic        ex_o,
  output logic        rd_we_o,
  output logic        illegal_o
);

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic        is_shift_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_u_s;
  logic [31:0] x_raw_s;
  logic [31:0] y_raw_s;
  logic [2:0]  ctrl_raw_s;
  logic        ex_raw_s;
  logic        legal_s;
  // rs1 index field is not needed: the register file has already been read
  logic        unused_rs1_idx_s;

  assign opcode_s   = instr[6:0];
  assign f3_s       = instr[14:12];
  assign f7_s       = instr[31:25];
  assign is_shift_s = (f3_s == 3'b001) || (f3_s == 3'b101);
  assign imm_i_s    = {{20{instr[31]}}, instr[31:20]};
  assign imm_u_s    = {instr[31:12], 12'd0};
  assign unused_rs1_idx_s = ^instr[19:15];

  // Opcode/funct decode into raw operands and a legality flag
  always_comb begin
    x_raw_s    = 32'd0;
    y_raw_s    = 32'd0;
    ctrl_raw_s = ALU_ADD;
    ex_raw_s   = 1'b0;
    legal_s    = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        x_raw_s    = rs1_data;
        ctrl_raw_s = map_f3(f3_s);
        if (is_shift_s) begin
          y_raw_s = {27'd0, rs2_data[4:0]};
        end else begin
          y_raw_s = rs2_data;
        end
        if (f7_s == F7_BASE) begin
          legal_s  = 1'b1;
          ex_raw_s = 1'b0;
        end else if (f7_s == F7_ALT) begin
          // Only SUB and SRA have an alternate form
          ex_raw_s = 1'b1;
          legal_s  = (f3_s == 3'b000) || (f3_s == 3'b101);
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OPIMM: begin
        x_raw_s    = rs1_data;
        ctrl_raw_s = map_f3(f3_s);
        if (f3_s == 3'b001) begin
          y_raw_s = {27'd0, instr[24:20]};
          legal_s = (f7_s == F7_BASE);
        end else if (f3_s == 3'b101) begin
          y_raw_s = {27'd0, instr[24:20]};
          if (f7_s == F7_BASE) begin
            legal_s  = 1'b1;
            ex_raw_s = 1'b0;
          end else if (f7_s == F7_ALT) begin
            legal_s  = 1'b1;
            ex_raw_s = 1'b1;
          end else begin
            legal_s = 1'b0;
          end
        end else begin
          y_raw_s = imm_i_s;
          legal_s = 1'b1;
        end
      end
      OPC_LUI: begin
        x_raw_s = 32'd0;
        y_raw_s = imm_u_s;
        legal_s = 1'b1;
      end
      OPC_AUIPC: begin
        x_raw_s = pc;
        y_raw_s = imm_u_s;
        legal_s = 1'b1;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Illegal slots carry a zeroed payload so the ALU sees a harmless add 0+0
  assign x_o       = legal_s ? x_raw_s    : 32'd0;
  assign y_o       = legal_s ? y_raw_s    : 32'd0;
  assign ctrl_o    = legal_s ? ctrl_raw_s : ALU_ADD;
  assign ex_o      = legal_s ? ex_raw_s   : 1'b0;
  assign rd_we_o   = legal_s && (instr[11:7] != 5'd0);
  assign illegal_o = !legal_s;

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-stage registered issue unit feeding the 32-bit ALU.
// Ports:
//   clk, rst_n (sync, active low), flush (sync, clears slot and HALT)
//   in_valid/in_ready, instr, pc, rs1_data, rs2_data   upstream side
//   out_valid/out_ready, alu_x, alu_y, alu_ctrl, alu_ex,
//   rd_addr, rd_we, illegal                            ALU side (registered)
// Optional feature macro ALU_ISSUE_PERF_EN adds issued_cnt[31:0] and
// illegal_cnt[15:0] drain counters (cleared by reset only).
// Accepting an illegal encoding moves the FSM to HALT; the illegal slot still
// drains, but no further instruction is accepted until flush.
module alu_issue
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [2:0]      alu_ctrl,
  output logic            alu_ex,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
`ifdef ALU_ISSUE_PERF_EN
  output logic [31:0]     issued_cnt,
  output logic [15:0]     illegal_cnt,
`endif
  output logic            illegal
);

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        ex_q, ex_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic        ill_q, ill_d;

  logic [31:0] dec_x_s;
  logic [31:0] dec_y_s;
  logic [2:0]  dec_ctrl_s;
  logic        dec_ex_s;
  logic        dec_we_s;
  logic        dec_ill_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        drain_s;

  alu_issue_dec u_dec (
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .x_o       (dec_x_s),
    .y_o       (dec_y_s),
    .ctrl_o    (dec_ctrl_s),
    .ex_o      (dec_ex_s),
    .rd_we_o   (dec_we_s),
    .illegal_o (dec_ill_s)
  );

  // Handshake: the slot can refill when empty or draining this cycle
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_RUN:  in_ready_s = !valid_q || out_ready;
      ST_HALT: in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign accept_s = in_valid && in_ready_s;
  assign drain_s  = valid_q && out_ready;

  // Next-state and output-slot update; flush wins over a same-cycle accept
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    ctrl_d  = ctrl_q;
    ex_d    = ex_q;
    rd_d    = rd_q;
    we_d    = we_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = ST_RUN;
      valid_d = 1'b0;
      x_d     = 32'd0;
      y_d     = 32'd0;
      ctrl_d  = ALU_ADD;
      ex_d    = 1'b0;
      rd_d    = 5'd0;
      we_d    = 1'b0;
      ill_d   = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      x_d     = dec_x_s;
      y_d     = dec_y_s;
      ctrl_d  = dec_ctrl_s;
      ex_d    = dec_ex_s;
      rd_d    = instr[11:7];
      we_d    = dec_we_s;
      ill_d   = dec_ill_s;
      if (dec_ill_s) begin
        state_d = ST_HALT;
      end else begin
        state_d = state_q;
      end
    end else if (drain_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output slot and FSM state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      ctrl_q  <= ALU_ADD;
      ex_q    <= 1'b0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ctrl_q  <= ctrl_d;
      ex_q    <= ex_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign alu_ctrl  = ctrl_q;
  assign alu_ex    = ex_q;
  assign rd_addr   = rd_q;
  assign rd_we     = we_q;
  assign illegal   = ill_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issued_cnt_q, issued_cnt_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  // Drain counters: legal drains wrap, illegal drains saturate
  always_comb begin
    issued_cnt_d  = issued_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (drain_s && !ill_q) begin
      issued_cnt_d = issued_cnt_q + 32'd1;
    end else if (drain_s && ill_q && (illegal_cnt_q != 16'hFFFF)) begin
      illegal_cnt_d = illegal_cnt_q + 16'd1;
    end else begin
      issued_cnt_d  = issued_cnt_q;
    end
  end

  // Counter registers survive flush, clear only on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_cnt_q  <= 32'd0;
      illegal_cnt_q <= 16'd0;
    end else begin
      issued_cnt_q  <= issued_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign issued_cnt  = issued_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Single-stage registered issue unit that drives the 32-bit integer ALU operand/control interface.
- Decodes RV32I OP, OP-IMM, LUI and AUIPC instructions, selects and forms the operands, and registers x, y, ctrl and ex for the ALU.
- Sits between register-file read and the execute stage, with valid/ready flow control on both sides.
- Halts on an illegal encoding until flushed.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous pipeline flush; clears the output register and leaves HALT
- in_valid  in  1  instr/operands valid
- in_ready  out  1  stage can accept
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register-file read of rs1
- rs2_data  in  32  register-file read of rs2
- out_valid  out  1  ALU operands valid
- out_ready  in  1  execute stage accepts
- alu_x  out  32  ALU operand x
- alu_y  out  32  ALU operand y
- alu_ctrl  out  3  ALU op select
- alu_ex  out  1  ALU modifier (SUB/SRA)
- rd_addr  out  5  destination register
- rd_we  out  1  writeback enable
- illegal  out  1  issued slot carries an illegal instruction

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, state RUN; in_ready=1 the cycle after reset.
- FSM states:
  - RUN: in_ready = !out_valid | out_ready.
  - HALT: in_ready=0.
- Transfers:
  - Accept = in_valid & in_ready.
  - Output drains when out_valid & out_ready.
  - Accept and drain can occur in the same cycle, giving full throughput.
- Latency: 1 cycle from accept to out_valid.
- Output registers hold stable while out_valid & !out_ready.
- ALU ctrl encoding:
  - 000 add / sub (ex=1)
  - 001 sll
  - 010 unsigned less-than
  - 011 signed less-than
  - 100 xor
  - 101 srl / sra (ex=1)
  - 110 or
  - 111 and
- funct3 remapping: funct3 010 (SLT/SLTI) maps to ctrl 011; funct3 011 (SLTU/SLTIU) maps to ctrl 010. All other funct3 values pass through unchanged.
- OP (0110011):
  - x=rs1_data.
  - y=rs2_data, except for shifts (funct3 001/101), where y={27'b0, rs2_data[4:0]}.
  - funct7 0000000 gives ex=0.
  - funct7 0100000 gives ex=1, legal only with funct3 000 or 101.
  - Any other funct7 is illegal.
- OP-IMM (0010011):
  - x=rs1_data, y=sign-extended instr[31:20], ex=0.
  - Shifts (funct3 001/101) use y={27'b0, instr[24:20]}.
  - For funct3 101, instr[31:25] must be 0000000 (srli, ex=0) or 0100000 (srai, ex=1).
  - For funct3 001, instr[31:25] must be 0000000.
  - Any other shift encoding is illegal.
- LUI (0110111): x=0, y={instr[31:12], 12'b0}, ctrl=000, ex=0.
- AUIPC (0010111): x=pc, y={instr[31:12], 12'b0}, ctrl=000, ex=0.
- rd_addr=instr[11:7]; rd_we=1 iff legal and rd_addr!=0.
- Any other opcode, or an illegal funct combination, is illegal:
  - Slot issued with illegal=1, rd_we=0, alu_ctrl=000, alu_ex=0, alu_x=0, alu_y=0.
  - FSM moves to HALT on that accept.
- HALT: the illegal slot drains normally; no new accepts until flush.
- flush:
  - Next edge: out_valid=0, illegal=0, state RUN.
  - Takes priority over a same-cycle accept; that instruction is dropped, and in_ready stays as computed, so the upstream must also flush.
- Reset during HALT or with a stalled slot: returns to the reset state; the pending slot is lost.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Defined:
  - Adds outputs issued_cnt[31:0] and illegal_cnt[15:0].
  - issued_cnt increments on every output drain of a legal slot.
  - illegal_cnt increments on drain of an illegal slot and saturates at 16'hFFFF.
  - Both clear on reset but not on flush; issued_cnt wraps modulo 2^32.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package rv32_pkg:
  - opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC.
  - ALU ctrl constants ALU_ADD … ALU_AND, including the SLT/SLTU remap values.
  - funct7 constants F7_BASE=0000000, F7_ALT=0100000.
- Sub-module alu_issue_dec: purely combinational decode of instr/pc/rs data into next x, y, ctrl, ex, rd_we, illegal. The top holds the FSM, handshake and output register.

Test Plan:
- Reset; then 0x00208133 (add x2,x1,x2) with rs1=5, rs2=7 → one cycle later out_valid=1, x=5, y=7, ctrl=000, ex=0, rd=2, rd_we=1.
- 0x40208133 (sub) then 0x0020A133 (slt), back-to-back with out_ready=1 → ex=1 ctrl=000, then ctrl=011; in_ready stays 1 throughout.
- srai x1,x1,3 (0x4030D093) → y=3, ctrl=101, ex=1. sll with rs2=0xFFFFFF21 → y=1.
- lui x5,0xABCDE with pc=0x100 → x=0, y=0xABCDE000. auipc x5,1 with pc=0x100 → x=0x100, y=0x1000.
- out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0, no instruction lost or duplicated.
- Opcode 0x0000007F → illegal=1, rd_we=0, in_ready=0 thereafter. Pulse flush → out_valid=0, in_ready=1. flush with a same-cycle accept → that instruction is not issued.
